// File: rtl/prbs7_checker.sv
// Serial PRBS7 (x^7 + x^6 + 1) receive checker: self-synchronises to the
// generator stream, flywheels while locked, and counts bit errors.
module prbs7_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 32,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 din_i,
    input  logic                 din_valid_i,
    output logic                 locked_o,
    output logic                 err_pulse_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [CNT_WIDTH-1:0] bit_count_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           hist_q, hist_d;
    logic [2:0]           fill_q, fill_d;
    logic [MW-1:0]        match_q, match_d;
    logic [WW-1:0]        win_q, win_d;
    logic [EW-1:0]        werr_q, werr_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

    logic predicted;
    logic miss;
    logic err_inc;
    logic bit_inc;

    assign predicted = hist_q[6] ^ hist_q[5];
    assign miss      = din_i != predicted;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;

        if (din_valid_i) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[5:0], din_i};
                    if (fill_q != 3'd7) begin
                        fill_d  = fill_q + 3'd1;
                        match_d = '0;
                    end else if (!miss && hist_q != 7'd0) begin
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the local prediction, not din, feeds the history
                    // so a single flipped bit cannot corrupt later predictions.
                    hist_d      = {hist_q[5:0], predicted};
                    bit_inc     = 1'b1;
                    err_inc     = miss;
                    err_pulse_d = miss;
                    if (win_q == WW'(WINDOW - 1)) begin
                        win_d  = '0;
                        werr_d = EW'(miss);
                    end else begin
                        win_d  = win_q + WW'(1);
                        werr_d = werr_q + EW'(miss);
                    end
                    if (werr_d == EW'(LOSS_THRESH)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clear_i) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            err_cnt_d = (err_inc && err_cnt_q != '1) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
            bit_cnt_d = (bit_inc && bit_cnt_q != '1) ? bit_cnt_q + CNT_WIDTH'(1) : bit_cnt_q;
        end

        locked_d = state_d == LOCKED;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_cnt_q;
    assign bit_count_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: a bit-history model of the checker is compared
// against two instances (16-bit and 4-bit counters) on every cycle.
module tb_prbs7_checker;

    localparam int LOCK_COUNT  = 16;
    localparam int WINDOW      = 32;
    localparam int LOSS_THRESH = 4;
    localparam logic [6:0] SEED = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b1;
    logic        clear = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count, bit_count;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_count, s_bit_count;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk_i(clk), .reset_ni(reset_ni), .clear_i(clear), .din_i(din),
        .din_valid_i(din_valid), .locked_o(locked), .err_pulse_o(err_pulse),
        .err_count_o(err_count), .bit_count_o(bit_count)
    );

    prbs7_checker #(.CNT_WIDTH(4)) dut_s (
        .clk_i(clk), .reset_ni(reset_ni), .clear_i(clear), .din_i(din),
        .din_valid_i(din_valid), .locked_o(s_locked), .err_pulse_o(s_err_pulse),
        .err_count_o(s_err_count), .bit_count_o(s_bit_count)
    );

    // ---------------- generator ----------------
    logic [6:0] g = SEED;
    function automatic bit gen_next();
        bit nb;
        nb = g[6] ^ g[5];
        g  = {g[5:0], nb};
        return nb;
    endfunction

    // ---------------- behavioural model ----------------
    // mh[0] is the oldest of the last seven history bits, mh[6] the newest.
    int    mh[7];
    int    m_locked = 0, m_pulse = 0, m_fill = 0, m_match = 0;
    int    m_since = 0, m_werr = 0;
    longint m_errs = 0, m_bits = 0;

    function automatic longint sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_push(input int b);
        for (int i = 0; i < 6; i++) mh[i] = mh[i + 1];
        mh[6] = b;
    endtask

    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 7; i++) mh[i] = 0;
            m_locked = 0; m_pulse = 0; m_fill = 0; m_match = 0;
            m_since = 0; m_werr = 0; m_errs = 0; m_bits = 0;
        end else begin
            int pred, nz, e;
            m_pulse = 0;
            if (din_valid) begin
                pred = mh[0] ^ mh[1];
                if (m_locked == 0) begin
                    nz = 0;
                    for (int i = 0; i < 7; i++) if (mh[i] != 0) nz = 1;
                    if (m_fill < 7) begin
                        m_fill++;
                        m_match = 0;
                    end else if (int'(din) == pred && nz == 1) begin
                        m_match++;
                        if (m_match == LOCK_COUNT) begin
                            m_locked = 1; m_match = 0; m_since = 0; m_werr = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                    model_push(int'(din));
                end else begin
                    e = (int'(din) != pred) ? 1 : 0;
                    m_bits++;
                    if (e == 1) begin m_errs++; m_pulse = 1; end
                    if (m_since % WINDOW == WINDOW - 1) m_werr = e;
                    else m_werr = m_werr + e;
                    m_since++;
                    if (m_werr == LOSS_THRESH) begin
                        m_locked = 0; m_fill = 0; m_match = 0;
                    end
                    model_push(pred);
                end
            end
            if (clear) begin m_errs = 0; m_bits = 0; end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc locked",        locked,      m_locked);
            chk("cyc err_pulse",     err_pulse,   m_pulse);
            chk("cyc err_count",     err_count,   sat(m_errs, 16));
            chk("cyc bit_count",     bit_count,   sat(m_bits, 16));
            chk("cyc s_locked",      s_locked,    m_locked);
            chk("cyc s_err_pulse",   s_err_pulse, m_pulse);
            chk("cyc s_err_count",   s_err_count, sat(m_errs, 4));
            chk("cyc s_bit_count",   s_bit_count, sat(m_bits, 4));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input bit b, input bit clr);
        @(negedge clk);
        din = b; din_valid = 1'b1; clear = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n, input bit clr);
        @(negedge clk);
        clear = clr;
        repeat (n) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset_ni = 1'b0; din_valid = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_ni = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " locked"},      locked,      0);
        chk({tag, " err_pulse"},   err_pulse,   0);
        chk({tag, " err_count"},   err_count,   0);
        chk({tag, " bit_count"},   bit_count,   0);
        chk({tag, " s_locked"},    s_locked,    0);
        chk({tag, " s_err_count"}, s_err_count, 0);
        chk({tag, " s_bit_count"}, s_bit_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first[4];
        bit b;
        int v, f, c, thr;

        // Reset and idle
        #2 reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        cmp_en = 1'b1;
        #1 reset_ni = 1'b1;
        idle(20, 1'b0);
        check_zero("idle");

        // Generator sanity: first bits from SEED are 0,1,0,1
        g = SEED;
        for (int i = 0; i < 4; i++) first[i] = gen_next();
        chk("gen bit0", first[0], 0);
        chk("gen bit1", first[1], 1);
        chk("gen bit2", first[2], 0);
        chk("gen bit3", first[3], 1);

        // Clean lock, back-to-back then with idle gaps
        for (int mode = 0; mode < 2; mode++) begin
            apply_reset();
            g = SEED;
            for (int i = 1; i <= 254; i++) begin
                send_bit(gen_next(), 1'b0);
                if (i == 22) chk("lock not yet at bit 22", locked, 0);
                if (i == 23) chk("lock at bit 23", locked, 1);
                if (mode == 1) idle(1, 1'b0);
            end
            chk("clean err_count", err_count, 0);
            chk("clean bit_count", bit_count, 231);
        end

        // Single error while locked
        idle(1, 1'b1);
        chk("clear bit_count", bit_count, 0);
        for (int i = 0; i < 10; i++) send_bit(gen_next(), 1'b0);
        send_bit(~gen_next(), 1'b0);
        chk("single err_pulse", err_pulse, 1);
        chk("single err_count", err_count, 1);
        send_bit(gen_next(), 1'b0);
        chk("single pulse width", err_pulse, 0);
        for (int i = 0; i < 50; i++) send_bit(gen_next(), 1'b0);
        chk("single err_count after", err_count, 1);
        chk("single still locked", locked, 1);

        // Loss of lock: four errors early in one window
        apply_reset();
        g = SEED;
        for (int i = 0; i < 23 + 8; i++) send_bit(gen_next(), 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(~gen_next(), 1'b0);
            if (i == 2) chk("loss locked after 3rd", locked, 1);
        end
        chk("loss locked after 4th", locked, 0);
        chk("loss err_count", err_count, 4);
        chk("loss err_pulse on 4th", err_pulse, 1);
        for (int i = 1; i <= 23; i++) begin
            send_bit(gen_next(), 1'b0);
            if (i == 22) chk("relock not yet", locked, 0);
        end
        chk("relock", locked, 1);
        chk("relock err_count", err_count, 4);

        // Degenerate streams
        apply_reset();
        for (int i = 0; i < 200; i++) send_bit(1'b0, 1'b0);
        for (int i = 0; i < 200; i++) send_bit(1'b1, 1'b0);
        chk("degenerate locked", locked, 0);

        // Saturation and clear
        apply_reset();
        g = SEED;
        for (int i = 0; i < 23; i++) send_bit(gen_next(), 1'b0);
        for (int e = 1; e <= 20; e++) begin
            for (int i = 0; i < 15; i++) send_bit(gen_next(), 1'b0);
            send_bit(~gen_next(), 1'b0);
            chk("sat s_err_count", s_err_count, (e > 15) ? 15 : e);
        end
        chk("sat err_count wide", err_count, 20);
        chk("sat still locked", locked, 1);
        send_bit(~gen_next(), 1'b1);
        chk("clear beats inc err", err_count, 0);
        chk("clear beats inc s_err", s_err_count, 0);
        chk("clear beats inc bits", bit_count, 0);
        chk("clear pulse", err_pulse, 1);
        for (int i = 0; i < 5; i++) send_bit(gen_next(), 1'b0);
        @(posedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #2 reset_ni = 1'b1;

        // Randomised stream with gaps, errors and clears
        g = 7'($urandom_range(1, 127));
        for (int cyc = 0; cyc < 5000; cyc++) begin
            thr = (cyc < 2500) ? 120 : 14;
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            c = ($urandom_range(0, 199) == 0) ? 1 : 0;
            if (v == 1) begin
                f = ($urandom_range(0, thr - 1) == 0) ? 1 : 0;
                b = gen_next() ^ f[0];
                send_bit(b, c[0]);
            end else begin
                idle(1, c[0]);
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
